bram_ctrl: RTL and testbench
============================

# bram_ctrl

On-chip memory responder for the core's two request ports: a read-only instruction-fetch port and a read/write data port. It serves both ports from one single-ported word RAM, using the same op/busy/done handshake the core already drives. It arbitrates between the ports and inserts a configurable number of wait states. It sits between `core` and a local RAM, and is used in builds or benches that run without the UART-backed memory path.

## Interface
- `ADDR_W`, 32: byte-address width of both ports.
- `DATA_W`, 32: word width; fixed at 32, so there are 4 byte lanes.
- `DEPTH_LOG2`, 14: log2 of the RAM size in words.
- `LATENCY`, 2: wait states between accept and RAM access (0..15).
- `INIT_FILE`, "": hex image loaded into the RAM at elaboration; empty means no load.
- `CLK`, in, 1: clock; all state changes on the rising edge.
- `RST`, in, 1: asynchronous reset, active-high.
- `read_op1`, in, 1: fetch-port read request (level).
- `addr1`, in, ADDR_W: fetch byte address.
- `data1_o`, out, DATA_W: fetch read data.
- `busy1`, out, 1: fetch request accepted and in service.
- `done1`, out, 1: one-cycle fetch completion pulse.
- `read_op2`, in, 1: data-port read request (level).
- `write_op`, in, 1: data-port write request (level).
- `addr2`, in, ADDR_W: data byte address.
- `data2_i`, in, DATA_W: write data.
- `mask`, in, 4: byte-lane write enables; bit i enables `data[8i+7:8i]`.
- `data2_o`, out, DATA_W: data-port read data.
- `busy2`, out, 1: data request accepted and in service.
- `done2`, out, 1: one-cycle data completion pulse.

## Operation
- States: IDLE, BUSY, DONE. A `sel` bit records the port being served, and `last` records the last port served.
- IDLE: at an edge, check each port's request.
  - Port 1 requests when `read_op1` is high.
  - Port 2 requests when `read_op2 | write_op` is high.
  - If exactly one port requests, accept it.
  - If both request, accept the port not equal to `last`. Reset sets `last`=1, so port 2 wins the first tie.
- On accept:
  - Latch the address, plus `write_op`, `data2_i` and `mask` for port 2.
  - Set `busyN`=1 and `cnt`=LATENCY, then go to BUSY.
- BUSY: at each edge, decrement `cnt` if it is nonzero. When `cnt`==0:
  - Perform the RAM access.
  - Register the read data into `dataN_o`, or apply the masked write.
  - Set `doneN`=1, update `last`, and go to DONE.
- DONE: at the next edge, clear `doneN` and `busyN` and go to IDLE. No new request is accepted at this edge.
- Address handling:
  - The word index is `addr[DEPTH_LOG2+1:2]`, and `addr[1:0]` is ignored.
  - If any bit above `DEPTH_LOG2+1` is set, the address is out of range. Reads then return 0 and writes are dropped, but the handshake completes normally.
- If `write_op` and `read_op2` are both high, the request is a write and `data2_o` is unchanged.
- A write with `mask`=0 changes nothing and still completes.
- `data1_o`/`data2_o` hold their last read value until the next read completes on the same port. Writes never change `data2_o`.
- Port inputs are sampled only at accept. Changes to the address or data during BUSY are ignored.

## Timing
- Reset: every output is 0, the state is IDLE, and `cnt`=0. RAM contents are not reset.
- Reset mid-operation: the access is abandoned. A write whose access edge has not yet occurred is not applied.
- Accept at edge E0 gives the following, with L = LATENCY:
  - `busyN` is high from E0 to E(L+2).
  - The RAM access happens at E(L+1).
  - `doneN` is high for exactly the cycle between E(L+1) and E(L+2).
  - `dataN_o` is valid from E(L+1).
- The earliest next accept is E(L+3). Throughput is one access per L+3 cycles.
- The requester must drop its op by the edge that ends `doneN`. If the op is still high in IDLE, it is treated as a new request.
- `busy1` and `busy2` are never high together, and neither are `done1` and `done2`.

## Test plan
- Fetch read, L=2, INIT word[4]=0xDEADBEEF:
  - Stimulus: `read_op1`=1 with `addr1`=0x10 at E0.
  - Response: `busy1` high E0..E4, `done1` high only between E3 and E4, `data1_o`=0xDEADBEEF.
- Masked write then read:
  - Stimulus: write 0x11223344 to 0x20 with `mask`=0xF, then write 0xAABBCCDD to the same address with `mask`=0x5, then read 0x20.
  - Response: `data2_o`=0x11BB33DD, and `data1_o` is unchanged.
- Simultaneous requests after reset:
  - Stimulus: both ports request at the same edge.
  - Response: port 2 is served first (`done2`). Port 1 is accepted at the first IDLE edge after `done2` and returns its data. The sequence repeats alternating, with no starvation.
- Out-of-range access, DEPTH_LOG2=14:
  - Stimulus: write 0xFFFFFFFF to 0x00010000, then read 0x00010000 and read 0x0.
  - Response: both `done2` pulses occur, the out-of-range read returns 0, and word 0 is unchanged.
- Reset mid-write:
  - Stimulus: assert RST one cycle after a write to 0x40 (L=2) is accepted.
  - Response: outputs clear immediately, and a later read of 0x40 returns the old value.
- Held request and LATENCY=0:
  - Stimulus: keep `read_op1` high through `done1`.
  - Response: a second access is accepted at E3, with `done1` pulses 3 cycles apart.

Source files
------------

// File: rtl/bram_ctrl_if.sv
// Fetch and data request ports between the core and bram_ctrl.
// master = core side, slave = memory responder side.
interface bram_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              read_op1;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] data1_o;
  logic              busy1;
  logic              done1;

  logic              read_op2;
  logic              write_op;
  logic [ADDR_W-1:0] addr2;
  logic [DATA_W-1:0] data2_i;
  logic [3:0]        mask;
  logic [DATA_W-1:0] data2_o;
  logic              busy2;
  logic              done2;

  modport master (
    output read_op1, addr1, read_op2, write_op, addr2, data2_i, mask,
    input  data1_o, busy1, done1, data2_o, busy2, done2
  );

  modport slave (
    input  read_op1, addr1, read_op2, write_op, addr2, data2_i, mask,
    output data1_o, busy1, done1, data2_o, busy2, done2
  );
endinterface

// File: rtl/bram_ctrl.sv
// Two-port (fetch / data) responder sharing one single-ported word RAM,
// with round-robin tie-breaking and LATENCY wait states per access.
// state  | meaning
// S_IDLE | waiting for a request; arbitrates and latches the winner
// S_BUSY | counting wait states, RAM access when cnt reaches 0
// S_DONE | done pulse cycle; returns to idle without accepting
module bram_ctrl #(
  parameter int    ADDR_W     = 32,
  parameter int    DATA_W     = 32,
  parameter int    DEPTH_LOG2 = 14,
  parameter int    LATENCY    = 2,
  parameter string INIT_FILE  = ""
) (
  input  logic       CLK,
  input  logic       RST,
  bram_ctrl_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t            state_q;
  logic              sel_q;   // 1: serving the data port
  logic              last_q;  // 1: data port was served last
  logic [3:0]        cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic              wr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [3:0]        mask_q;
  logic [DATA_W-1:0] data1_q;
  logic [DATA_W-1:0] data2_q;
  logic              busy1_q;
  logic              busy2_q;
  logic              done1_q;
  logic              done2_q;

  logic [DATA_W-1:0] mem [0:(1<<DEPTH_LOG2)-1];

  logic                  req1;
  logic                  req2;
  logic                  pick2;
  logic                  in_range;
  logic                  access;
  logic                  we;
  logic [DEPTH_LOG2-1:0] idx;
  logic [DATA_W-1:0]     rd_word;

  assign req1     = bus.read_op1;
  assign req2     = bus.read_op2 | bus.write_op;
  assign pick2    = req2 & (~req1 | ~last_q);
  assign idx      = addr_q[DEPTH_LOG2+1:2];
  assign in_range = (addr_q >> (DEPTH_LOG2 + 2)) == '0;
  assign access   = (state_q == S_BUSY) && (cnt_q == 4'd0);
  assign we       = access && wr_q && in_range;
  assign rd_word  = in_range ? mem[idx] : '0;

  always_ff @(posedge CLK) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (mask_q[b]) mem[idx][8*b +: 8] <= wdata_q[8*b +: 8];
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      sel_q   <= 1'b0;
      last_q  <= 1'b0;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
      mask_q  <= 4'd0;
      data1_q <= '0;
      data2_q <= '0;
      busy1_q <= 1'b0;
      busy2_q <= 1'b0;
      done1_q <= 1'b0;
      done2_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req1 || req2) begin
            sel_q   <= pick2;
            addr_q  <= pick2 ? bus.addr2 : bus.addr1;
            wr_q    <= pick2 & bus.write_op;
            wdata_q <= bus.data2_i;
            mask_q  <= bus.mask;
            busy1_q <= ~pick2;
            busy2_q <= pick2;
            cnt_q   <= 4'(LATENCY);
            state_q <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            // A write leaves both read registers untouched.
            if (!wr_q) begin
              if (sel_q) data2_q <= rd_word;
              else       data1_q <= rd_word;
            end
            done1_q <= ~sel_q;
            done2_q <= sel_q;
            last_q  <= sel_q;
            state_q <= S_DONE;
          end
        end
        default: begin
          done1_q <= 1'b0;
          done2_q <= 1'b0;
          busy1_q <= 1'b0;
          busy2_q <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.data1_o = data1_q;
  assign bus.data2_o = data2_q;
  assign bus.busy1   = busy1_q;
  assign bus.busy2   = busy2_q;
  assign bus.done1   = done1_q;
  assign bus.done2   = done2_q;

endmodule

// File: tb/tb_bram_ctrl.sv
// Directed bench for bram_ctrl: LATENCY=2 instance for most cases and a
// LATENCY=0 instance for the held-request back-to-back case.
module tb_bram_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_pass = 0;
  int   n_fail = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  bram_ctrl_if ifa ();
  bram_ctrl_if ifb ();

  bram_ctrl #(.LATENCY(2)) dut_a (.CLK(clk), .RST(rst), .bus(ifa));
  bram_ctrl #(.LATENCY(0), .DEPTH_LOG2(4)) dut_b (.CLK(clk), .RST(rst), .bus(ifb));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Data-port transaction on instance A; called with the controller idle.
  task automatic op2(input logic rd, input logic wr, input logic [31:0] a,
                     input logic [31:0] d, input logic [3:0] m, input string tag);
    int   n;
    logic got;
    ifa.read_op2 = rd;
    ifa.write_op = wr;
    ifa.addr2    = a;
    ifa.data2_i  = d;
    ifa.mask     = m;
    tick();
    chk({tag, "_busy"}, 32'(ifa.busy2), 32'd1);
    ifa.read_op2 = 1'b0;
    ifa.write_op = 1'b0;
    n = 0;
    got = 1'b0;
    while (!got && n < 20) begin
      tick();
      n++;
      got = ifa.done2;
    end
    chk({tag, "_done"}, 32'(got), 32'd1);
    tick();
  endtask

  initial begin
    int   cyc;
    int   prev;
    int   both_busy;
    int   n;
    logic got;

    ifa.read_op1 = 0; ifa.addr1 = 0; ifa.read_op2 = 0; ifa.write_op = 0;
    ifa.addr2 = 0; ifa.data2_i = 0; ifa.mask = 0;
    ifb.read_op1 = 0; ifb.addr1 = 0; ifb.read_op2 = 0; ifb.write_op = 0;
    ifb.addr2 = 0; ifb.data2_i = 0; ifb.mask = 0;

    #12;
    chk("rst_busy1", 32'(ifa.busy1), 32'd0);
    chk("rst_busy2", 32'(ifa.busy2), 32'd0);
    chk("rst_done1", 32'(ifa.done1), 32'd0);
    chk("rst_done2", 32'(ifa.done2), 32'd0);
    chk("rst_data1", ifa.data1_o, 32'd0);
    chk("rst_data2", ifa.data2_o, 32'd0);
    rst = 1'b0;
    tick();

    op2(1'b0, 1'b1, 32'h0,  32'hCAFEF00D, 4'hF, "wr0");
    op2(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, "wr10");
    op2(1'b0, 1'b1, 32'h40, 32'h55667788, 4'hF, "wr40");

    // Fetch read timing, L=2
    ifa.read_op1 = 1'b1;
    ifa.addr1    = 32'h10;
    tick();
    chk("f_e0_busy", 32'(ifa.busy1), 32'd1);
    chk("f_e0_done", 32'(ifa.done1), 32'd0);
    ifa.read_op1 = 1'b0;
    ifa.addr1    = 32'h0;
    for (int i = 1; i <= 2; i++) begin
      tick();
      chk("f_wait_busy", 32'(ifa.busy1), 32'd1);
      chk("f_wait_done", 32'(ifa.done1), 32'd0);
    end
    tick();
    chk("f_e3_busy", 32'(ifa.busy1), 32'd1);
    chk("f_e3_done", 32'(ifa.done1), 32'd1);
    chk("f_e3_data", ifa.data1_o, 32'hDEADBEEF);
    chk("f_e3_done2", 32'(ifa.done2), 32'd0);
    tick();
    chk("f_e4_busy", 32'(ifa.busy1), 32'd0);
    chk("f_e4_done", 32'(ifa.done1), 32'd0);

    // Masked write then read
    op2(1'b0, 1'b1, 32'h20, 32'h11223344, 4'hF, "mw_full");
    op2(1'b0, 1'b1, 32'h20, 32'hAABBCCDD, 4'h5, "mw_part");
    op2(1'b1, 1'b0, 32'h20, 32'h0, 4'h0, "mw_rd");
    chk("mw_data2", ifa.data2_o, 32'h11BB33DD);
    chk("mw_data1_kept", ifa.data1_o, 32'hDEADBEEF);

    // Reset one cycle after a write to 0x40 is accepted
    ifa.write_op = 1'b1;
    ifa.addr2    = 32'h40;
    ifa.data2_i  = 32'h99999999;
    ifa.mask     = 4'hF;
    tick();
    chk("mr_busy", 32'(ifa.busy2), 32'd1);
    ifa.write_op = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    chk("mr_busy2", 32'(ifa.busy2), 32'd0);
    chk("mr_done2", 32'(ifa.done2), 32'd0);
    chk("mr_data1", ifa.data1_o, 32'd0);
    chk("mr_data2", ifa.data2_o, 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // Simultaneous requests held high: alternate starting with port 2
    ifa.read_op1 = 1'b1;
    ifa.addr1    = 32'h10;
    ifa.read_op2 = 1'b1;
    ifa.addr2    = 32'h20;
    cyc = 0;
    prev = 0;
    both_busy = 0;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      got = 1'b0;
      while (!got && n < 20) begin
        tick();
        cyc++;
        n++;
        if ((ifa.busy1 && ifa.busy2) || (ifa.done1 && ifa.done2)) both_busy++;
        got = ifa.done1 | ifa.done2;
      end
      if (k == 3) begin
        ifa.read_op1 = 1'b0;
        ifa.read_op2 = 1'b0;
      end
      chk("tie_seen", 32'(got), 32'd1);
      chk("tie_port2", 32'(ifa.done2), 32'(k % 2 == 0));
      chk("tie_data", (k % 2 == 0) ? ifa.data2_o : ifa.data1_o,
          (k % 2 == 0) ? 32'h11BB33DD : 32'hDEADBEEF);
      if (k > 0) chk("tie_spacing", 32'(cyc - prev), 32'd5);
      prev = cyc;
    end
    tick();
    chk("tie_exclusive", 32'(both_busy), 32'd0);
    chk("tie_idle", 32'(ifa.busy1 | ifa.busy2), 32'd0);

    op2(1'b1, 1'b0, 32'h40, 32'h0, 4'h0, "mr_rd");
    chk("mr_old_value", ifa.data2_o, 32'h55667788);

    // Out-of-range accesses
    op2(1'b0, 1'b1, 32'h00010000, 32'hFFFFFFFF, 4'hF, "oor_wr");
    op2(1'b1, 1'b0, 32'h00010000, 32'h0, 4'h0, "oor_rd");
    chk("oor_rd_zero", ifa.data2_o, 32'd0);
    op2(1'b1, 1'b0, 32'h0, 32'h0, 4'h0, "w0_rd");
    chk("w0_kept", ifa.data2_o, 32'hCAFEF00D);

    // Read+write together is a write; mask 0 write is a no-op
    op2(1'b1, 1'b1, 32'h20, 32'h01020304, 4'h8, "rw_both");
    chk("rw_data2_kept", ifa.data2_o, 32'hCAFEF00D);
    op2(1'b0, 1'b1, 32'h20, 32'hFFFFFFFF, 4'h0, "mask0");
    op2(1'b1, 1'b0, 32'h23, 32'h0, 4'h0, "rd23");
    chk("rd23_data", ifa.data2_o, 32'h01BB33DD);

    // LATENCY=0 instance: held fetch gives done1 every 3 cycles
    ifb.write_op = 1'b1;
    ifb.addr2    = 32'h4;
    ifb.data2_i  = 32'h0BADCAFE;
    ifb.mask     = 4'hF;
    tick();
    chk("l0_wr_busy", 32'(ifb.busy2), 32'd1);
    ifb.write_op = 1'b0;
    tick();
    chk("l0_wr_done", 32'(ifb.done2), 32'd1);
    tick();
    ifb.read_op1 = 1'b1;
    ifb.addr1    = 32'h4;
    cyc = 0;
    prev = 0;
    for (int k = 0; k < 2; k++) begin
      n = 0;
      got = 1'b0;
      while (!got && n < 10) begin
        tick();
        cyc++;
        n++;
        got = ifb.done1;
      end
      if (k == 1) ifb.read_op1 = 1'b0;
      chk("l0_seen", 32'(got), 32'd1);
      chk("l0_data", ifb.data1_o, 32'h0BADCAFE);
      chk("l0_when", 32'(cyc - prev), (k == 0) ? 32'd2 : 32'd3);
      prev = cyc;
    end
    tick();
    tick();
    chk("l0_idle", 32'(ifb.busy1), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
